// File: rtl/uart_cmd_responder.sv
// UART-side command responder: parses write/read frames, drives a byte-wide register bus and returns one response byte.
// Latency: reg_we 1 cycle / reg_re 1 cycle after the last byte; tx_start 2 (write) or 3 (read) cycles after it.
// Backpressure: holds the response in SEND while tx_busy is high; optional trailing XOR byte under UART_RESP_CHECKSUM_EN.
module uart_cmd_responder #(
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [7:0]  CMD_WR   = 8'h57;
    localparam logic [7:0]  CMD_RD   = 8'h52;
    localparam logic [7:0]  RSP_ACK  = 8'h4B;
    localparam logic [7:0]  RSP_BAD  = 8'h3F;
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS_WR,
        BUS_RD,
        RD_CAP,
        SEND,
        SEND_HOLD
`ifdef UART_RESP_CHECKSUM_EN
        , GET_SUM
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        cmd_wr_q, cmd_wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic        ferr_q, ferr_d;
    logic        tmo_hit;
`ifdef UART_RESP_CHECKSUM_EN
    localparam logic [7:0] RSP_SUM = 8'h21;
    logic [7:0]  sum_q, sum_d;
`endif

    assign tmo_hit = (cnt_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        cmd_wr_d  = cmd_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_byte_d = tx_byte_q;
        ferr_d    = 1'b0;
`ifdef UART_RESP_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
                        cmd_wr_d = (rx_byte == CMD_WR);
                        state_d  = GET_ADDR;
`ifdef UART_RESP_CHECKSUM_EN
                        sum_d    = rx_byte;
`endif
                    end else begin
                        tx_byte_d = RSP_BAD;
                        ferr_d    = 1'b1;
                        state_d   = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    addr_d = rx_byte;
`ifdef UART_RESP_CHECKSUM_EN
                    sum_d   = sum_q ^ rx_byte;
                    state_d = cmd_wr_q ? GET_DATA : GET_SUM;
`else
                    state_d = cmd_wr_q ? GET_DATA : BUS_RD;
`endif
                end else if (tmo_hit) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    wdata_d = rx_byte;
`ifdef UART_RESP_CHECKSUM_EN
                    sum_d   = sum_q ^ rx_byte;
                    state_d = GET_SUM;
`else
                    state_d = BUS_WR;
`endif
                end else if (tmo_hit) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
`ifdef UART_RESP_CHECKSUM_EN
            GET_SUM: begin
                if (rx_valid) begin
                    if (rx_byte == sum_q) begin
                        state_d = cmd_wr_q ? BUS_WR : BUS_RD;
                    end else begin
                        tx_byte_d = RSP_SUM;
                        ferr_d    = 1'b1;
                        state_d   = SEND;
                    end
                end else if (tmo_hit) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
`endif
            BUS_WR: begin
                ferr_d    = rx_valid;
                tx_byte_d = RSP_ACK;
                state_d   = SEND;
            end
            BUS_RD: begin
                ferr_d  = rx_valid;
                state_d = RD_CAP;
            end
            RD_CAP: begin
                ferr_d    = rx_valid;
                tx_byte_d = reg_rdata;
                state_d   = SEND;
            end
            SEND: begin
                ferr_d = rx_valid;
                if (!tx_busy) state_d = SEND_HOLD;
            end
            SEND_HOLD: begin
                // The UART raises tx_busy one cycle late, so it is not trusted here.
                ferr_d  = rx_valid;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Strobes are registered off the next state so they line up with BUS_WR/BUS_RD.
        we_d = (state_d == BUS_WR);
        re_d = (state_d == BUS_RD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_wr_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_byte_q <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RESP_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_wr_q  <= cmd_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_byte_q <= tx_byte_d;
            we_q      <= we_d;
            re_q      <= re_d;
            ferr_q    <= ferr_d;
`ifdef UART_RESP_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign tx_start  = (state_q == SEND) && !tx_busy;
    assign tx_byte   = tx_byte_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: frames driven byte by byte, bus/UART events logged and compared.
module tb_uart_cmd_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'hEE;
    logic       busy;
    logic       frame_err;

    uart_cmd_responder #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_cyc = 0;

    int we_cnt, re_cnt, txs_cnt, ferr_cnt;
    int we_cyc, re_cyc, txs_cyc, ferr_cyc;
    logic [7:0] we_addr, we_data, re_addr, txs_byte;
    logic [7:0] rd_val = 8'h3C;
    logic re_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        re_seen = reg_re;
        if (reg_we) begin we_cnt++; we_cyc = cyc; we_addr = reg_addr; we_data = reg_wdata; end
        if (reg_re) begin re_cnt++; re_cyc = cyc; re_addr = reg_addr; end
        if (tx_start) begin txs_cnt++; txs_cyc = cyc; txs_byte = tx_byte; end
        if (frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
    end

    // Read data is only valid in the cycle right after reg_re.
    always @(posedge clk) begin
        logic pend;
        pend = re_seen;
        #1 reg_rdata = pend ? rd_val : 8'hEE;
    end

    task automatic clr();
        we_cnt = 0; re_cnt = 0; txs_cnt = 0; ferr_cnt = 0;
        we_cyc = -1; re_cyc = -1; txs_cyc = -1; ferr_cyc = -1;
        we_addr = 0; we_data = 0; re_addr = 0; txs_byte = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        last_cyc = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input bit add_sum);
        logic [7:0] s;
        s = b0;
        send_byte(b0);
        if (n > 1) begin send_byte(b1); s = s ^ b1; end
        if (n > 2) begin send_byte(b2); s = s ^ b2; end
`ifdef UART_RESP_CHECKSUM_EN
        if (add_sum) send_byte(s);
`else
        if (add_sum && s == 8'h00) check("sum_unused", 32'(s), 32'(s) + 1);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int rel_cyc;
        clr();
        idle(2);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_reg_we", 32'(reg_we), 0);
        check("rst_reg_re", 32'(reg_re), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_reg_addr", 32'(reg_addr), 0);
        check("rst_reg_wdata", 32'(reg_wdata), 0);
        rst = 1'b0;
        idle(2);

        // Write 0x57,0x10,0xA5
        clr();
        send_frame(3, 8'h57, 8'h10, 8'hA5, 1'b1);
        idle(8);
        check("wr_we_cnt", 32'(we_cnt), 1);
        check("wr_addr", 32'(we_addr), 32'h10);
        check("wr_data", 32'(we_data), 32'hA5);
        check("wr_we_lat", 32'(we_cyc - last_cyc), 1);
        check("wr_txs_cnt", 32'(txs_cnt), 1);
        check("wr_txs_byte", 32'(txs_byte), 32'h4B);
        check("wr_txs_lat", 32'(txs_cyc - last_cyc), 2);
        check("wr_re_cnt", 32'(re_cnt), 0);
        check("wr_ferr", 32'(ferr_cnt), 0);
        check("wr_idle", 32'(busy), 0);

        // Read 0x52,0x22 returns 0x3C
        clr();
        rd_val = 8'h3C;
        send_frame(2, 8'h52, 8'h22, 8'h00, 1'b1);
        idle(8);
        check("rd_re_cnt", 32'(re_cnt), 1);
        check("rd_addr", 32'(re_addr), 32'h22);
        check("rd_re_lat", 32'(re_cyc - last_cyc), 1);
        check("rd_txs_cnt", 32'(txs_cnt), 1);
        check("rd_txs_byte", 32'(txs_byte), 32'h3C);
        check("rd_txs_lat", 32'(txs_cyc - last_cyc), 3);
        check("rd_we_cnt", 32'(we_cnt), 0);

        // Unknown command byte
        clr();
        send_byte(8'h41);
        idle(6);
        check("bad_ferr", 32'(ferr_cnt), 1);
        check("bad_txs_cnt", 32'(txs_cnt), 1);
        check("bad_txs_byte", 32'(txs_byte), 32'h3F);
        check("bad_strobes", 32'(we_cnt + re_cnt), 0);

        // Timeout after a partial write
        clr();
        send_frame(2, 8'h57, 8'h10, 8'h00, 1'b0);
        idle(30);
        check("tmo_ferr", 32'(ferr_cnt), 1);
        check("tmo_window", 32'((ferr_cyc - last_cyc) >= 13 && (ferr_cyc - last_cyc) <= 20), 1);
        check("tmo_no_tx", 32'(txs_cnt), 0);
        check("tmo_no_we", 32'(we_cnt), 0);
        check("tmo_idle", 32'(busy), 0);
        clr();
        send_frame(3, 8'h57, 8'h33, 8'h5A, 1'b1);
        idle(8);
        check("tmo_wr_we", 32'(we_cnt), 1);
        check("tmo_wr_data", 32'({we_addr, we_data}), 32'h335A);
        check("tmo_wr_txs", 32'(txs_byte), 32'h4B);

        // Read response stalled by tx_busy, with a byte dropped during the stall
        clr();
        rd_val = 8'h96;
        tx_busy = 1'b1;
        send_frame(2, 8'h52, 8'h44, 8'h00, 1'b1);
        idle(20);
        send_byte(8'h57);
        idle(80);
        check("stall_drop_ferr", 32'(ferr_cnt), 1);
        check("stall_no_tx", 32'(txs_cnt), 0);
        check("stall_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        tx_busy = 1'b0;
        rel_cyc = cyc;
        idle(6);
        check("stall_txs_cnt", 32'(txs_cnt), 1);
        check("stall_txs_cyc", 32'(txs_cyc - rel_cyc), 0);
        check("stall_txs_byte", 32'(txs_byte), 32'h96);
        check("stall_idle", 32'(busy), 0);
        check("stall_no_we", 32'(we_cnt), 0);

        // Asynchronous reset in the middle of a write frame
        clr();
        send_frame(2, 8'h57, 8'h10, 8'h00, 1'b0);
        check("mid_addr_latched", 32'(reg_addr), 32'h10);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_addr", 32'(reg_addr), 0);
        check("mid_rst_outs", 32'({tx_start, reg_we, reg_re, frame_err}), 0);
        check("mid_rst_tx_byte", 32'(tx_byte), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(30);
        check("mid_rst_events", 32'(we_cnt + re_cnt + txs_cnt + ferr_cnt), 0);

`ifdef UART_RESP_CHECKSUM_EN
        // Checksum byte mismatch
        clr();
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'hA5);
        send_byte(8'h00);
        idle(8);
        check("sum_bad_txs", 32'(txs_byte), 32'h21);
        check("sum_bad_we", 32'(we_cnt), 0);
        check("sum_bad_ferr", 32'(ferr_cnt), 1);
        clr();
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'hA5);
        send_byte(8'hE2);
        idle(8);
        check("sum_ok_we", 32'(we_cnt), 1);
        check("sum_ok_txs", 32'(txs_byte), 32'h4B);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
